imm_rot_encoder: RTL

//  Inverse of the bshift immediate path. bshift decodes imm12 = {rot[3:0], imm8} as

---
 rtl/imm_rot_encoder.sv | 115 +++++++++++
 1 files changed

// File: rtl/imm_rot_encoder.sv
// Encoder for the bshift rotated-immediate form: finds imm12 = {rot, imm8} with
// imm8 ROR (2*rot) == value, testing one rotation per clock.
module imm_rot_encoder #(
    parameter int N          = 32,
    parameter bit EARLY_EXIT = 1'b1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] value,
    output logic         busy,
    output logic         done,
    output logic         found,
    output logic [11:0]  imm12,
    output logic         c_out,
    output logic         c_valid
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SEARCH = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;
    localparam logic [5:0] WIDTH     = 6'(N);

    logic [1:0]   state_q, state_d;
    logic [3:0]   rot_q, rot_d;
    logic [N-1:0] value_q, value_d;
    logic         found_q, found_d;
    logic [11:0]  imm12_q, imm12_d;
    logic         c_out_q, c_out_d;
    logic         c_valid_q, c_valid_d;

    logic [4:0]   rot_amt;
    logic [N-1:0] cand;
    logic         match;

    // Undo the decoder's ROR by rotating left; a shift by the full width yields zero,
    // so rot 0 needs no special case.
    always_comb begin
        rot_amt = {rot_q, 1'b0};
        cand    = (value_q << rot_amt) | (value_q >> (WIDTH - {1'b0, rot_amt}));
        match   = (cand[N-1:8] == '0);
    end

    always_comb begin
        state_d   = state_q;
        rot_d     = rot_q;
        value_d   = value_q;
        found_d   = found_q;
        imm12_d   = imm12_q;
        c_out_d   = c_out_q;
        c_valid_d = c_valid_q;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    value_d   = value;
                    rot_d     = 4'd0;
                    found_d   = 1'b0;
                    imm12_d   = 12'h000;
                    c_out_d   = 1'b0;
                    c_valid_d = 1'b0;
                    state_d   = ST_SEARCH;
                end
            end
            ST_SEARCH: begin
                // Only the first (smallest) matching rotation is ever recorded.
                if (match && !found_q) begin
                    found_d   = 1'b1;
                    imm12_d   = {rot_q, cand[7:0]};
                    c_out_d   = (rot_q != 4'd0) && value_q[N-1];
                    c_valid_d = (rot_q != 4'd0);
                end
                if ((EARLY_EXIT && match) || (rot_q == 4'd15)) begin
                    state_d = ST_DONE;
                end else begin
                    rot_d = rot_q + 4'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            rot_q     <= 4'd0;
            value_q   <= '0;
            found_q   <= 1'b0;
            imm12_q   <= 12'h000;
            c_out_q   <= 1'b0;
            c_valid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            rot_q     <= rot_d;
            value_q   <= value_d;
            found_q   <= found_d;
            imm12_q   <= imm12_d;
            c_out_q   <= c_out_d;
            c_valid_q <= c_valid_d;
        end
    end

    assign busy    = (state_q == ST_SEARCH) || (state_q == ST_DONE);
    assign done    = (state_q == ST_DONE);
    assign found   = found_q;
    assign imm12   = imm12_q;
    assign c_out   = c_out_q;
    assign c_valid = c_valid_q;

endmodule
